// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scan bytes to Hack key codes, with held-key register, modifiers and an event FIFO
module ps2_key_decoder #(
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH = 8,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_ready,
  input  logic [7:0]           scan_code,
  output logic [OUT_WIDTH-1:0] key,
  output logic                 ev_valid,
  output logic [OUT_WIDTH-1:0] ev_data,
  input  logic                 ev_ready,
  output logic                 caps_lock,
  output logic                 shift,
  output logic                 overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, state_nx;
  logic ready_q, acc, ext, do_make, do_brk, mapped, push, pop, full, wr;
  logic shl, shr, caps_held;
  logic [7:0] code, key_q;
  logic [8:0] scan_id, held;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;

  function automatic logic [7:0] map_key(input logic x, input logic [7:0] sc, input logic sh, input logic up);
    logic [7:0] c;
    c = 8'h00;
    if (x) begin
      case (sc)
        8'h6B: c = 8'd130;
        8'h75: c = 8'd131;
        8'h74: c = 8'd132;
        8'h72: c = 8'd133;
        8'h6C: c = 8'd134;
        8'h69: c = 8'd135;
        8'h7D: c = 8'd136;
        8'h7A: c = 8'd137;
        8'h70: c = 8'd138;
        8'h71: c = 8'd139;
        default: c = 8'h00;
      endcase
    end else begin
      case (sc)
        8'h1C: c = up ? "A" : "a";
        8'h32: c = up ? "B" : "b";
        8'h21: c = up ? "C" : "c";
        8'h23: c = up ? "D" : "d";
        8'h24: c = up ? "E" : "e";
        8'h2B: c = up ? "F" : "f";
        8'h34: c = up ? "G" : "g";
        8'h33: c = up ? "H" : "h";
        8'h43: c = up ? "I" : "i";
        8'h3B: c = up ? "J" : "j";
        8'h42: c = up ? "K" : "k";
        8'h4B: c = up ? "L" : "l";
        8'h3A: c = up ? "M" : "m";
        8'h31: c = up ? "N" : "n";
        8'h44: c = up ? "O" : "o";
        8'h4D: c = up ? "P" : "p";
        8'h15: c = up ? "Q" : "q";
        8'h2D: c = up ? "R" : "r";
        8'h1B: c = up ? "S" : "s";
        8'h2C: c = up ? "T" : "t";
        8'h3C: c = up ? "U" : "u";
        8'h2A: c = up ? "V" : "v";
        8'h1D: c = up ? "W" : "w";
        8'h22: c = up ? "X" : "x";
        8'h35: c = up ? "Y" : "y";
        8'h1A: c = up ? "Z" : "z";
        8'h16: c = sh ? "!" : "1";
        8'h1E: c = sh ? "@" : "2";
        8'h26: c = sh ? "#" : "3";
        8'h25: c = sh ? "$" : "4";
        8'h2E: c = sh ? "%" : "5";
        8'h36: c = sh ? "^" : "6";
        8'h3D: c = sh ? "&" : "7";
        8'h3E: c = sh ? "*" : "8";
        8'h46: c = sh ? "(" : "9";
        8'h45: c = sh ? ")" : "0";
        8'h0E: c = sh ? "~" : 8'h60;
        8'h4E: c = sh ? "_" : "-";
        8'h55: c = sh ? "+" : "=";
        8'h54: c = sh ? "{" : "[";
        8'h5B: c = sh ? "}" : "]";
        8'h5D: c = sh ? "|" : 8'h5C;
        8'h4C: c = sh ? ":" : ";";
        8'h52: c = sh ? 8'h22 : 8'h27;
        8'h41: c = sh ? "<" : ",";
        8'h49: c = sh ? ">" : ".";
        8'h4A: c = sh ? "?" : "/";
        8'h29: c = 8'h20;
        8'h5A: c = 8'd128;
        8'h66: c = 8'd129;
        8'h76: c = 8'd140;
        8'h05: c = 8'd141;
        8'h06: c = 8'd142;
        8'h04: c = 8'd143;
        8'h0C: c = 8'd144;
        8'h03: c = 8'd145;
        8'h0B: c = 8'd146;
        8'h83: c = 8'd147;
        8'h0A: c = 8'd148;
        8'h01: c = 8'd149;
        8'h09: c = 8'd150;
        8'h78: c = 8'd151;
        8'h07: c = 8'd152;
        default: c = 8'h00;
      endcase
    end
    return c;
  endfunction

  assign acc = scan_ready & ~ready_q;

  always_ff @(posedge clk) begin
    ready_q <= reset ? 1'b0 : scan_ready;
    if (reset) state <= IDLE;
    else if (acc) state <= state_nx;
  end

  always_comb begin
    state_nx = state == IDLE ? (scan_code == 8'hE0 ? EXT : scan_code == 8'hF0 ? BRK : IDLE) :
               state == EXT  ? (scan_code == 8'hF0 ? EXT_BRK : IDLE) : IDLE;
  end

  // prefixes and keyboard status replies are consumed in IDLE without producing a make
  always_comb begin
    ext = state == EXT || state == EXT_BRK;
    do_brk = acc && (state == BRK || state == EXT_BRK);
    do_make = acc && (state == IDLE ? !(scan_code inside {8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hE1}) :
                      state == EXT && scan_code != 8'hF0);
  end

  assign scan_id = {ext, scan_code};
  assign code = map_key(ext, scan_code, shift, shift ^ caps_lock);
  assign mapped = code != 8'h00;
  assign push = do_make && mapped && (REPEAT_EN || scan_id != held);
  assign shift = shl | shr;

  always_ff @(posedge clk) begin
    if (reset) begin
      shl <= 1'b0;
      shr <= 1'b0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
      key_q <= 8'h00;
      held <= 9'h000;
    end else begin
      shl <= scan_id == 9'h012 && do_make ? 1'b1 : scan_id == 9'h012 && do_brk ? 1'b0 : shl;
      shr <= scan_id == 9'h059 && do_make ? 1'b1 : scan_id == 9'h059 && do_brk ? 1'b0 : shr;
      caps_lock <= scan_id == 9'h058 && do_make && !caps_held ? ~caps_lock : caps_lock;
      caps_held <= scan_id == 9'h058 && do_make ? 1'b1 : scan_id == 9'h058 && do_brk ? 1'b0 : caps_held;
      if (do_make && mapped) begin
        key_q <= code;
        held <= scan_id;
      end else if (do_brk && held != 9'h000 && scan_id == held) begin
        key_q <= 8'h00;
        held <= 9'h000;
      end
    end
  end

  assign pop = ev_valid && ev_ready;
  assign full = count == (AW+1)'(DEPTH);
  assign wr = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      overflow <= overflow | (push && full && !pop);
    end
  end

  assign ev_valid = count != '0;
  assign ev_data = OUT_WIDTH'(mem[rp]);
  assign key = OUT_WIDTH'(key_q);
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed tests for the PS/2 scan decoder, one task per scenario
module tb_ps2_key_decoder;
  logic clk = 1'b0, reset, scan_ready, ev_ready, ev_ready0;
  logic [7:0] scan_code;
  logic [15:0] key, ev_data, key0, ev_data0;
  logic ev_valid, caps_lock, shift, overflow;
  logic ev_valid0, caps_lock0, shift0, overflow0;
  logic [15:0] got[$];
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.OUT_WIDTH(16), .DEPTH(8), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code), .key(key),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready), .caps_lock(caps_lock),
    .shift(shift), .overflow(overflow));

  ps2_key_decoder #(.OUT_WIDTH(16), .DEPTH(8), .REPEAT_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code), .key(key0),
    .ev_valid(ev_valid0), .ev_data(ev_data0), .ev_ready(ev_ready0), .caps_lock(caps_lock0),
    .shift(shift0), .overflow(overflow0));

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    scan_code = b;
    scan_ready = 1'b1;
    repeat (5) @(negedge clk);
    scan_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input bit sel, output int n);
    got.delete();
    if (sel) ev_ready0 = 1'b1;
    else ev_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(sel ? ev_valid0 : ev_valid)) break;
      got.push_back(sel ? ev_data0 : ev_data);
      @(negedge clk);
    end
    ev_ready = 1'b0;
    ev_ready0 = 1'b0;
    n = got.size();
  endtask

  task automatic test_reset();
    do_reset();
    compared += 5;
    if (key !== 16'h0) begin mismatched++; $display("FAIL reset_key got %h want 0", key); end
    if (ev_valid !== 1'b0) begin mismatched++; $display("FAIL reset_ev_valid got %b want 0", ev_valid); end
    if (caps_lock !== 1'b0) begin mismatched++; $display("FAIL reset_caps got %b want 0", caps_lock); end
    if (shift !== 1'b0) begin mismatched++; $display("FAIL reset_shift got %b want 0", shift); end
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_letter();
    int n;
    do_reset();
    scan_code = 8'h1C;
    scan_ready = 1'b1;
    @(negedge clk);
    compared += 2;
    if (key !== 16'h0061) begin mismatched++; $display("FAIL letter_latency_key got %h want 0061", key); end
    if (ev_valid !== 1'b1) begin mismatched++; $display("FAIL letter_latency_valid got %b want 1", ev_valid); end
    repeat (4) @(negedge clk);
    scan_ready = 1'b0;
    repeat (2) @(negedge clk);
    send(8'hF0);
    compared++;
    if (key !== 16'h0061) begin mismatched++; $display("FAIL letter_f0_key got %h want 0061", key); end
    send(8'h1C);
    compared++;
    if (key !== 16'h0) begin mismatched++; $display("FAIL letter_break_key got %h want 0", key); end
    drain(1'b0, n);
    compared += 2;
    if (n !== 1) begin mismatched++; $display("FAIL letter_count got %0d want 1", n); end
    if (got[0] !== 16'h0061) begin mismatched++; $display("FAIL letter_event got %h want 0061", got[0]); end
  endtask

  task automatic test_caps_shift();
    int n;
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58);
    compared++;
    if (caps_lock !== 1'b1) begin mismatched++; $display("FAIL caps_on got %b want 1", caps_lock); end
    send(8'h32);
    compared++;
    if (key !== 16'h0042) begin mismatched++; $display("FAIL caps_B got %h want 0042", key); end
    send(8'hF0); send(8'h32);
    compared++;
    if (key !== 16'h0) begin mismatched++; $display("FAIL caps_break got %h want 0", key); end
    send(8'h12);
    compared += 2;
    if (shift !== 1'b1) begin mismatched++; $display("FAIL shift_on got %b want 1", shift); end
    if (key !== 16'h0) begin mismatched++; $display("FAIL shift_no_key got %h want 0", key); end
    send(8'h32);
    compared++;
    if (key !== 16'h0062) begin mismatched++; $display("FAIL shift_caps_b got %h want 0062", key); end
    send(8'hF0); send(8'h12);
    compared += 2;
    if (shift !== 1'b0) begin mismatched++; $display("FAIL shift_off got %b want 0", shift); end
    if (key !== 16'h0062) begin mismatched++; $display("FAIL case_fixed got %h want 0062", key); end
    send(8'h16);
    compared++;
    if (key !== 16'h0031) begin mismatched++; $display("FAIL digit_caps got %h want 0031", key); end
    drain(1'b0, n);
    compared += 4;
    if (n !== 3) begin mismatched++; $display("FAIL caps_count got %0d want 3", n); end
    if (got[0] !== 16'h0042) begin mismatched++; $display("FAIL caps_ev0 got %h want 0042", got[0]); end
    if (got[1] !== 16'h0062) begin mismatched++; $display("FAIL caps_ev1 got %h want 0062", got[1]); end
    if (got[2] !== 16'h0031) begin mismatched++; $display("FAIL caps_ev2 got %h want 0031", got[2]); end
  endtask

  task automatic test_special();
    int n;
    do_reset();
    send(8'hE0); send(8'h6B);
    compared++;
    if (key !== 16'd130) begin mismatched++; $display("FAIL ext_left got %0d want 130", key); end
    send(8'hE0); send(8'hF0); send(8'h6B);
    compared++;
    if (key !== 16'd0) begin mismatched++; $display("FAIL ext_break got %0d want 0", key); end
    send(8'h5A);
    compared++;
    if (key !== 16'd128) begin mismatched++; $display("FAIL enter got %0d want 128", key); end
    send(8'hF0); send(8'h5A); send(8'h66);
    compared++;
    if (key !== 16'd129) begin mismatched++; $display("FAIL backspace got %0d want 129", key); end
    send(8'hF0); send(8'h66); send(8'h76);
    compared++;
    if (key !== 16'd140) begin mismatched++; $display("FAIL esc got %0d want 140", key); end
    send(8'hF0); send(8'h76); send(8'h0F);
    compared++;
    if (key !== 16'd0) begin mismatched++; $display("FAIL unmapped got %0d want 0", key); end
    drain(1'b0, n);
    compared += 5;
    if (n !== 4) begin mismatched++; $display("FAIL special_count got %0d want 4", n); end
    if (got[0] !== 16'd130) begin mismatched++; $display("FAIL special_ev0 got %0d want 130", got[0]); end
    if (got[1] !== 16'd128) begin mismatched++; $display("FAIL special_ev1 got %0d want 128", got[1]); end
    if (got[2] !== 16'd129) begin mismatched++; $display("FAIL special_ev2 got %0d want 129", got[2]); end
    if (got[3] !== 16'd140) begin mismatched++; $display("FAIL special_ev3 got %0d want 140", got[3]); end
  endtask

  task automatic test_overflow();
    int n, n0;
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h1C);
    compared += 2;
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    if (overflow0 !== 1'b0) begin mismatched++; $display("FAIL ovf_norepeat got %b want 0", overflow0); end
    drain(1'b0, n);
    drain(1'b1, n0);
    compared += 4;
    if (n !== 8) begin mismatched++; $display("FAIL ovf_count got %0d want 8", n); end
    if (got.size() != 0 && got[0] !== 16'h0061) begin mismatched++; $display("FAIL ovf_norepeat_data got %h want 0061", got[0]); end
    if (n0 !== 1) begin mismatched++; $display("FAIL norepeat_count got %0d want 1", n0); end
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_after_drain got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] codes [8] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
    do_reset();
    for (int i = 0; i < 8; i++) send(codes[i]);
    scan_code = 8'h43;
    scan_ready = 1'b1;
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    repeat (4) @(negedge clk);
    scan_ready = 1'b0;
    repeat (2) @(negedge clk);
    compared += 2;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    if (key !== 16'h0069) begin mismatched++; $display("FAIL b2b_key got %h want 0069", key); end
    drain(1'b0, n);
    compared++;
    if (n !== 8) begin mismatched++; $display("FAIL b2b_count got %0d want 8", n); end
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (k >= got.size() || got[k] !== 16'h0062 + 16'(k)) begin
        mismatched++;
        $display("FAIL b2b_order[%0d] got %h want %h", k, k < got.size() ? got[k] : 16'hxxxx, 16'h0062 + 16'(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h6B);
    compared += 2;
    if (key !== 16'h0) begin mismatched++; $display("FAIL midreset_key got %h want 0", key); end
    if (ev_valid !== 1'b0) begin mismatched++; $display("FAIL midreset_valid got %b want 0", ev_valid); end
    send(8'h1C);
    compared++;
    if (key !== 16'h0061) begin mismatched++; $display("FAIL midreset_idle got %h want 0061", key); end
  endtask

  initial begin
    reset = 1'b1;
    scan_ready = 1'b0;
    scan_code = 8'h00;
    ev_ready = 1'b0;
    ev_ready0 = 1'b0;
    @(negedge clk);
    test_reset();
    test_letter();
    test_caps_shift();
    test_special();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
